// File: rtl/sync_decoder.sv
// Video sync decoder: measures hSync/vSync/dataValid timing, locks onto a stable
// format, and reports active-pixel coordinates with one pclk of latency.
module sync_decoder #(
    parameter int unsigned CNT_MAX = 1023
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic       hSync,
    input  logic       vSync,
    input  logic       dataValid,
    output logic       pixValid,
    output logic [9:0] hPos,
    output logic [9:0] vPos,
    output logic [9:0] hTotal,
    output logic [9:0] vTotal,
    output logic [9:0] hActive,
    output logic [9:0] vActive,
    output logic       locked,
    output logic       frameStart,
    output logic       timingErr
);

    typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} state_t;

    localparam logic [9:0] CMAX = 10'(CNT_MAX);

    function automatic logic [9:0] satInc(input logic [9:0] v);
        return (v >= CMAX) ? CMAX : v + 10'd1;
    endfunction

    state_t     state;
    state_t     nextState;
    logic       hsD;
    logic       vsD;
    logic [9:0] hCnt;
    logic [9:0] vCnt;
    logic [9:0] actCnt;
    logic [9:0] lineLen;
    logic [9:0] firstLen;
    logic       haveLen;
    logic       consist;
    logic [9:0] frmHAct;
    logic [9:0] frmVAct;
    logic [9:0] row;

    logic       hEdge;
    logic       vEdge;
    logic       sat;
    logic       lineDone;
    logic       lenOk;
    logic       frameMatch;
    logic       dvRise;
    logic [9:0] curLen;
    logic [9:0] effHAct;
    logic [9:0] effVAct;
    logic [9:0] rowNext;
    logic       loadRef;
    logic       loadHTot;
    logic       errNext;

    assign hEdge  = hsD & ~hSync;
    assign vEdge  = vsD & ~vSync;
    // A line that just ended resets hCnt, so it cannot count as saturation.
    assign sat    = (hCnt == CMAX) && !hEdge;
    assign dvRise = dataValid & ~pixValid;
    assign locked = (state == LOCKED);

    // Effective frame values fold in the line that closes on a coincident hSync edge.
    assign lineDone   = hEdge && (actCnt != 10'd0);
    assign effHAct    = lineDone ? actCnt : frmHAct;
    assign effVAct    = lineDone ? satInc(frmVAct) : frmVAct;
    assign curLen     = hEdge ? hCnt : lineLen;
    assign lenOk      = !hEdge || !haveLen || (hCnt == firstLen);
    assign frameMatch = consist && lenOk && (curLen == hTotal) && (vCnt == vTotal) &&
                        (effHAct == hActive) && (effVAct == vActive);

    always_comb begin
        rowNext = vEdge ? 10'd0 : row;
        if (dvRise) rowNext = satInc(rowNext);
    end

    always_comb begin
        nextState = state;
        loadRef   = 1'b0;
        loadHTot  = 1'b0;
        errNext   = 1'b0;
        if (sat) begin
            nextState = SEARCH;
            errNext   = (state == LOCKED);
        end else begin
            case (state)
                SEARCH: if (vEdge) nextState = MEASURE;
                MEASURE: begin
                    if (vEdge) begin
                        loadRef   = 1'b1;
                        nextState = VERIFY;
                    end
                end
                VERIFY: begin
                    if (vEdge) begin
                        if (frameMatch) nextState = LOCKED;
                        else            loadRef   = 1'b1;
                    end
                end
                LOCKED: begin
                    if (vEdge && !frameMatch) begin
                        errNext   = 1'b1;
                        loadRef   = 1'b1;
                        nextState = VERIFY;
                    end else if (hEdge && (hCnt != hTotal)) begin
                        errNext   = 1'b1;
                        loadHTot  = 1'b1;
                        nextState = VERIFY;
                    end
                end
                default: nextState = SEARCH;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (!reset) state <= SEARCH;
        else        state <= nextState;
    end

    always_ff @(posedge pclk) begin
        if (!reset) begin
            hsD        <= 1'b0;
            vsD        <= 1'b0;
            hCnt       <= '0;
            vCnt       <= '0;
            actCnt     <= '0;
            lineLen    <= '0;
            firstLen   <= '0;
            haveLen    <= 1'b0;
            consist    <= 1'b0;
            frmHAct    <= '0;
            frmVAct    <= '0;
            row        <= '0;
            hTotal     <= '0;
            vTotal     <= '0;
            hActive    <= '0;
            vActive    <= '0;
            pixValid   <= 1'b0;
            hPos       <= '0;
            vPos       <= '0;
            frameStart <= 1'b0;
            timingErr  <= 1'b0;
        end else begin
            hsD <= hSync;
            vsD <= vSync;

            if (hEdge) begin
                hCnt    <= 10'd1;
                lineLen <= hCnt;
                vCnt    <= satInc(vCnt);
                actCnt  <= '0;
                if (lineDone) begin
                    frmHAct <= actCnt;
                    frmVAct <= satInc(frmVAct);
                end
                if (!haveLen) begin
                    firstLen <= hCnt;
                    haveLen  <= 1'b1;
                end else if (hCnt != firstLen) begin
                    consist <= 1'b0;
                end
            end else begin
                hCnt <= satInc(hCnt);
                if (dataValid) actCnt <= satInc(actCnt);
            end

            // Frame accumulators restart after the closing frame has been captured.
            if (vEdge) begin
                vCnt    <= 10'd1;
                frmHAct <= '0;
                frmVAct <= '0;
                haveLen <= 1'b0;
                consist <= 1'b1;
            end

            if (loadRef) begin
                hTotal  <= curLen;
                vTotal  <= vCnt;
                hActive <= effHAct;
                vActive <= effVAct;
            end else if (loadHTot) begin
                hTotal <= hCnt;
            end

            row        <= rowNext;
            pixValid   <= dataValid;
            hPos       <= dataValid ? (pixValid ? satInc(hPos) : 10'd1) : 10'd0;
            vPos       <= dataValid ? rowNext : 10'd0;
            frameStart <= vEdge;
            timingErr  <= errNext;
        end
    end

endmodule

// File: tb/tb_sync_decoder.sv
// Scoreboard bench for sync_decoder using a reduced 40x12 video format
// (sync 4 clocks / 2 lines, 28 active pixels x 7 active lines).
module tb_sync_decoder;

    localparam int H_TOT   = 40;
    localparam int H_SYNC  = 4;
    localparam int H_ACT_S = 9;
    localparam int H_ACT_E = 36;
    localparam int V_TOT   = 12;
    localparam int V_SYNC  = 2;
    localparam int V_ACT_S = 4;
    localparam int V_ACT_E = 10;

    localparam int K_RST = 0;
    localparam int K_FS  = 1;
    localparam int K_ERR = 2;
    localparam int K_PS  = 3;
    localparam int K_PE  = 4;

    typedef struct {
        int         kind;
        bit         chkLock;
        bit         lockExp;
        bit         chkRef;
        logic [9:0] hExp;
        logic [9:0] vExp;
    } exp_t;

    logic       pclk = 1'b0;
    logic       reset = 1'b0;
    logic       hSync = 1'b1;
    logic       vSync = 1'b1;
    logic       dataValid = 1'b0;
    logic       pixValid;
    logic [9:0] hPos, vPos, hTotal, vTotal, hActive, vActive;
    logic       locked, frameStart, timingErr;

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    logic       rstQ = 1'b1;
    bit         endReq = 1'b0;
    bit         prevPix = 1'b0;
    logic [9:0] prevH = '0;
    logic [9:0] prevV = '0;

    sync_decoder #(.CNT_MAX(1023)) dut (
        .pclk(pclk), .reset(reset), .hSync(hSync), .vSync(vSync), .dataValid(dataValid),
        .pixValid(pixValid), .hPos(hPos), .vPos(vPos), .hTotal(hTotal), .vTotal(vTotal),
        .hActive(hActive), .vActive(vActive), .locked(locked), .frameStart(frameStart),
        .timingErr(timingErr)
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk) rstQ <= reset;

    function automatic string kname(input int k);
        case (k)
            K_RST:   return "reset_state";
            K_FS:    return "frame_start";
            K_ERR:   return "timing_err";
            K_PS:    return "first_pixel";
            default: return "last_pixel";
        endcase
    endfunction

    function automatic void pushEv(input int kind, input bit chkLock, input bit lockExp,
                                   input bit chkRef, input int h, input int v);
        exp_t e;
        e.kind    = kind;
        e.chkLock = chkLock;
        e.lockExp = lockExp;
        e.chkRef  = chkRef;
        e.hExp    = 10'(h);
        e.vExp    = 10'(v);
        q.push_back(e);
    endfunction

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic popCheck(input int kind);
        exp_t e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: event seen with none expected at %0t", kname(kind), $time);
            return;
        end
        e = q.pop_front();
        if (e.kind != kind) begin
            checks++;
            errors++;
            $display("FAIL order: got %s expected %s at %0t", kname(kind), kname(e.kind), $time);
            return;
        end
        case (kind)
            K_RST: cmp("reset_outputs",
                       {pixValid, hPos, vPos, hTotal, vTotal, hActive, vActive,
                        locked, frameStart, timingErr}, 64'd0);
            K_FS: begin
                if (e.chkLock) cmp("fs_locked", 64'(locked), 64'(e.lockExp));
                if (e.chkRef)  cmp("fs_reference", 64'({hTotal, vTotal, hActive, vActive}),
                                   64'({10'd40, 10'd12, 10'd28, 10'd7}));
            end
            K_ERR: cmp("err_locked", 64'(locked), 64'(e.lockExp));
            K_PS:  cmp("first_pixel_pos", 64'({hPos, vPos}), 64'({e.hExp, e.vExp}));
            default: cmp("last_pixel_pos", 64'({prevH, prevV, hPos, vPos}),
                         64'({e.hExp, e.vExp, 10'd0, 10'd0}));
        endcase
    endtask

    always @(negedge pclk) begin
        if (endReq) begin
            cmp("queue_drained", 64'(q.size()), 64'd0);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end else if (!rstQ) begin
            popCheck(K_RST);
            prevPix = 1'b0;
            prevH   = '0;
            prevV   = '0;
        end else begin
            if (frameStart)           popCheck(K_FS);
            if (timingErr)            popCheck(K_ERR);
            if (pixValid && !prevPix) popCheck(K_PS);
            if (!pixValid && prevPix) popCheck(K_PE);
            prevPix = pixValid;
            prevH   = hPos;
            prevV   = vPos;
        end
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // One frame; longLine stretches that line by one clock, holdLine freezes hSync
    // high after that line, rstLine pulses reset in the middle of that line.
    task automatic runFrame(input int longLine, input int holdLine, input int rstLine,
                            input bit chkLock, input bit lockExp, input bit chkRef);
        for (int ln = 1; ln <= V_TOT; ln++) begin
            int len;
            len = (ln == longLine) ? H_TOT + 1 : H_TOT;
            for (int c = 1; c <= len; c++) begin
                bit act;
                act       = (ln >= V_ACT_S) && (ln <= V_ACT_E);
                hSync     = (c > H_SYNC);
                vSync     = (ln > V_SYNC);
                dataValid = act && (c >= H_ACT_S) && (c <= H_ACT_E);
                if (ln == 1 && c == 1) pushEv(K_FS, chkLock, lockExp, chkRef, 0, 0);
                if (longLine > 0 && ln == longLine + 1 && c == 1) pushEv(K_ERR, 1, 0, 0, 0, 0);
                if (act && c == H_ACT_S)
                    pushEv(K_PS, 0, 0, 0, 1, ln - V_ACT_S + 1);
                if (act && c == H_ACT_E + 1)
                    pushEv(K_PE, 0, 0, 0, H_ACT_E - H_ACT_S + 1, ln - V_ACT_S + 1);
                if (ln == rstLine && c == 20) begin
                    reset     = 1'b0;
                    hSync     = 1'b1;
                    vSync     = 1'b1;
                    dataValid = 1'b0;
                    pushEv(K_RST, 0, 0, 0, 0, 0);
                    tick();
                    reset = 1'b1;
                    return;
                end
                tick();
            end
            if (ln == holdLine) begin
                pushEv(K_ERR, 1, 0, 0, 0, 0);
                hSync     = 1'b1;
                vSync     = 1'b1;
                dataValid = 1'b0;
                repeat (1030) tick();
                return;
            end
        end
    endtask

    initial begin
        reset     = 1'b0;
        hSync     = 1'b1;
        vSync     = 1'b1;
        dataValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pushEv(K_RST, 0, 0, 0, 0, 0);
            tick();
        end
        reset = 1'b1;
        repeat (5) tick();

        runFrame(0, 0, 0, 1, 0, 0);  // edge 1: SEARCH -> MEASURE
        runFrame(0, 0, 0, 1, 0, 0);  // edge 2: reference captured
        runFrame(0, 0, 0, 1, 1, 1);  // edge 3: locked
        runFrame(0, 0, 0, 1, 1, 1);  // edge 4: stays locked
        runFrame(3, 0, 0, 1, 1, 1);  // edge 5: locked, then a 41-clock line
        runFrame(0, 0, 0, 1, 0, 0);  // edge 6: inconsistent frame, unlocked
        runFrame(0, 0, 0, 0, 0, 0);  // edge 7: after first clean frame
        runFrame(0, 3, 0, 1, 1, 1);  // edge 8: locked again, then hSync stalls
        runFrame(0, 0, 0, 1, 0, 0);  // edge 9: SEARCH -> MEASURE
        runFrame(0, 0, 0, 1, 0, 0);  // edge 10
        runFrame(0, 0, 5, 1, 1, 1);  // edge 11: relocked, reset mid-line
        repeat (30) tick();
        endReq = 1'b1;
    end

endmodule
